// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader: imem geometry, NOP fill
// value and loader FSM state codes.
package instr_loader_pkg;

  localparam int          IMEM_ADDR_W = 10;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_FILL,
    S_DONE
  } state_t;

  // Byte address of imem word `idx` relative to `base`.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles four consecutive stream bytes into a 32-bit little-endian word;
// word_valid pulses combinationally on the fourth byte.
module instr_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] lo;

  // The fourth byte is never stored; it is spliced straight into the word.
  assign word       = {in_data, lo};
  assign word_valid = in_valid && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      lo  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (in_valid) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0:    lo[7:0]   <= in_data;
        2'd1:    lo[15:8]  <= in_data;
        2'd2:    lo[23:16] <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory writer: parses a length-prefixed byte stream, writes the
// packed words to imem and optionally pads the remaining words with NOPs.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          ADDR_W     = IMEM_ADDR_W,
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter bit          FILL_NOP   = 1'b1,
  parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [31:0] DEPTH_32 = 32'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t          state, state_nx;
  logic [15:0]     len;
  logic [ADDR_W:0] word_idx;
  logic [15:0]     hdr_len;
  logic [31:0]     cur_addr;
  logic            last_word, last_fill, fill_after;
  logic            pk_in, pk_valid;
  logic [31:0]     pk_word;
  logic            start, lat_lo, lat_hi, reject, wr_data, wr_fill, finish;

  assign in_ready   = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
  assign hdr_len    = {in_data, len[7:0]};
  assign cur_addr   = word_addr(START_ADDR, 32'(word_idx[ADDR_W-1:0]));
  assign last_word  = (32'(word_idx) + 32'd1) == 32'(len);
  assign last_fill  = (word_idx == LAST_IDX);
  assign fill_after = FILL_NOP && (32'(len) < DEPTH_32);
  assign pk_in      = in_valid && (state == S_DATA);

  instr_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .in_valid   (pk_in),
    .in_data    (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    lat_lo   = 1'b0;
    lat_hi   = 1'b0;
    reject   = 1'b0;
    wr_data  = 1'b0;
    wr_fill  = 1'b0;
    finish   = 1'b0;
    case (state)
      S_IDLE: if (load_start) begin
        start    = 1'b1;
        state_nx = S_HDR0;
      end
      S_HDR0: if (in_valid) begin
        lat_lo   = 1'b1;
        state_nx = S_HDR1;
      end
      S_HDR1: if (in_valid) begin
        lat_hi = 1'b1;
        if (32'(hdr_len) > DEPTH_32) begin
          reject   = 1'b1;
          state_nx = S_IDLE;
        end else if (hdr_len == 16'd0) begin
          state_nx = FILL_NOP ? S_FILL : S_DONE;
        end else begin
          state_nx = S_DATA;
        end
      end
      // Leaving DATA on the last byte lets the final data write and the first
      // NOP write land on consecutive cycles.
      S_DATA: if (pk_valid) begin
        wr_data = 1'b1;
        if (last_word) state_nx = fill_after ? S_FILL : S_DONE;
      end
      S_FILL: begin
        wr_fill = 1'b1;
        if (last_fill) state_nx = S_DONE;
      end
      S_DONE: begin
        finish   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      word_idx <= '0;
      we       <= 1'b0;
      waddr    <= START_ADDR;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        len      <= '0;
        word_idx <= '0;
      end
      if (lat_lo) len[7:0]  <= in_data;
      if (lat_hi) len[15:8] <= in_data;
      if (reject) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
      if (wr_data || wr_fill) begin
        we       <= 1'b1;
        wdata    <= wr_data ? pk_word : NOP_WORD;
        waddr    <= cur_addr;
        word_idx <= word_idx + 1'b1;
      end
      // busy drops together with done, after the final write has been issued.
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: program load, empty load, oversize reject,
// stream gaps, mid-load reset and ignored load_start pulses.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  instr_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: compares every imem write against the expected image.
  logic [31:0] prog[2];
  int          nprog;
  logic        mon_clr = 1'b0;
  int cyc = 0, nb = 0, nw = 0, bad = 0, badlat = 0, last4 = -10;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      nb <= 0; nw <= 0; bad <= 0; badlat <= 0; last4 <= -10;
    end else if (rst_n) begin
      if (in_valid && in_ready) begin
        nb <= nb + 1;
        if (nb + 1 > 2 && ((nb + 1 - 2) % 4) == 0) last4 <= cyc;
      end
      if (we) begin
        if (waddr != 32'(nw * 4) || wdata != ((nw < nprog) ? prog[nw] : NOP)) bad <= bad + 1;
        if (nw < nprog && last4 != cyc - 1) badlat <= badlat + 1;
        nw <= nw + 1;
      end
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap, t;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("byte_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 3000) begin @(posedge clk); #1; t++; end
    chk({tag, "_done_to"}, 32'(t < 3000), 32'd1);
  endtask

  logic [7:0] img[10];

  // Full load of the two-instruction image; gap_max adds random in_valid gaps,
  // poke pulses load_start during DATA and FILL.
  task automatic run_load(input string tag, input int gap_max, input bit poke);
    clear_mon();
    pulse_start();
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (poke && i == 5) load_start = 1'b1;
      send_byte(img[i], gap_max);
      load_start = 1'b0;
    end
    if (poke) begin
      repeat (3) begin
        repeat (40) begin @(posedge clk); #1; end
        pulse_start();
      end
    end
    wait_done(tag);
    chk({tag, "_nwrites"}, 32'(nw), 32'd1024);
    chk({tag, "_bad_writes"}, 32'(bad), 32'd0);
    chk({tag, "_latency"}, 32'(badlat), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    img = '{8'h02, 8'h00, 8'h13, 8'h03, 8'h40, 8'h01, 8'h93, 8'h03, 8'he0, 8'h01};
    prog[0] = 32'h0140_0313;
    prog[1] = 32'h01e0_0393;
    nprog = 2;
    rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", waddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-word program, NOP fill to end of memory
    run_load("t1", 0, 1'b0);

    // 2: empty image -> whole memory filled with NOP
    nprog = 0;
    clear_mon();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_done("t2");
    chk("t2_nwrites", 32'(nw), 32'd1024);
    chk("t2_bad_writes", 32'(bad), 32'd0);

    // 3: length 1025 rejected
    clear_mon();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_nwrites", 32'(nw), 32'd0);

    // 4: same image with random stream gaps
    nprog = 2;
    run_load("t4", 3, 1'b0);

    // 5: reset after six bytes, then a clean reload
    clear_mon();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", 32'(we), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_waddr", waddr, 32'h0);
    chk("t5_rst_wdata", wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load("t5", 0, 1'b0);

    // 6: load_start pulses mid-load are ignored
    run_load("t6", 1, 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
